// File: rtl/dsp_mac_sequencer_if.sv
// Bundle for dsp_mac_sequencer: operand stream, DSP48A1 control/return, result stream.
// Optional macro DSP_SEQ_OVF_EN adds the res_ovf result flag.
interface dsp_mac_sequencer_if;
  localparam int unsigned OP_W  = 18;
  localparam int unsigned P_W   = 48;
  localparam int unsigned OPM_W = 8;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             in_last;
  logic [OP_W-1:0]  DSP_A;
  logic [OP_W-1:0]  DSP_B;
  logic [OPM_W-1:0] DSP_OPMODE;
  logic             DSP_CE;
  logic             DSP_RST;
  logic [P_W-1:0]   DSP_P;
  logic             DSP_CARRYOUT;
  logic             res_valid;
  logic             res_ready;
  logic [P_W-1:0]   res_data;
`ifdef DSP_SEQ_OVF_EN
  logic             res_ovf;
`endif
  logic             busy;

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_last, DSP_P, DSP_CARRYOUT, res_ready,
`ifdef DSP_SEQ_OVF_EN
    output res_ovf,
`endif
    output in_ready, DSP_A, DSP_B, DSP_OPMODE, DSP_CE, DSP_RST, res_valid, res_data, busy
  );

  // Environment side (operand source, slice, result sink)
  modport master (
    output in_valid, in_a, in_b, in_last, DSP_P, DSP_CARRYOUT, res_ready,
`ifdef DSP_SEQ_OVF_EN
    input  res_ovf,
`endif
    input  in_ready, DSP_A, DSP_B, DSP_OPMODE, DSP_CE, DSP_RST, res_valid, res_data, busy
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a DSP48A1 slice (A1/B1/M/P/OPMODE registered) so that
// each in_last-delimited frame accumulates sum(a*b) in P, then captures P into a
// 2-entry result FIFO. Optional macro DSP_SEQ_OVF_EN adds a per-frame carry flag.
module dsp_mac_sequencer #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned P_LAT   = 1
) (
  input logic                CLK,
  input logic                RSTN,
  dsp_mac_sequencer_if.slave bus
);
  localparam int unsigned OP_W       = 18;
  localparam int unsigned P_W        = 48;
  localparam int unsigned OPM_W      = 8;
  localparam int unsigned DEPTH      = MUL_LAT + P_LAT + 1;
  localparam int unsigned OPM_STAGE  = MUL_LAT - 1;
  localparam int unsigned CRED_W     = 2;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;
  localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;
  localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;

  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_FRAME} state_e;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  typedef struct packed {
`ifdef DSP_SEQ_OVF_EN
    logic           ovf;
`endif
    logic [P_W-1:0] data;
  } entry_t;

  state_e             state_q, state_d;
  tag_t               tag_q [1:DEPTH];
  tag_t               tag_in_c;
  logic [CRED_W-1:0]  credits_q, credits_d;
  logic [CRED_W-1:0]  count_q, count_d;
  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  entry_t             wr_entry_c;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               accept_c, first_c, capture_c, pop_c, pipe_busy_c;
  logic [OPM_W-1:0]   opmode_d;
  logic               in_ready_q, in_ready_d;
  logic               res_valid_d, busy_d;
  logic [OP_W-1:0]    dsp_a_q, dsp_b_q;
  logic [OPM_W-1:0]   dsp_opmode_q;
  logic               dsp_ce_q, dsp_rst_q;
  logic               res_valid_q, busy_q;
  logic [P_W-1:0]     res_data_q;
`ifdef DSP_SEQ_OVF_EN
  logic               ovf_sticky_q, ovf_sticky_d;
  logic               res_ovf_q;
`else
  logic               unused_carryout;
  assign unused_carryout = bus.DSP_CARRYOUT;
`endif

  // State register: reset-release step, then idle/in-frame tracking
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= ST_RST;
    else       state_q <= state_d;
  end

  // Next state, tag insertion, credits, FIFO bookkeeping and opmode selection
  always_comb begin
    state_d     = state_q;
    accept_c    = bus.in_valid && in_ready_q;
    first_c     = (state_q != ST_FRAME);
    tag_in_c    = '0;
    capture_c   = tag_q[DEPTH].vld && tag_q[DEPTH].last;
    pop_c       = res_valid_q && bus.res_ready;
    mem_d       = mem_q;
    wr_entry_c  = '0;
    pipe_busy_c = accept_c;
    opmode_d    = OPM_HOLD;

    case (state_q)
      ST_RST:   state_d = ST_IDLE;
      ST_IDLE:  if (accept_c && !bus.in_last) state_d = ST_FRAME;
      ST_FRAME: if (accept_c &&  bus.in_last) state_d = ST_IDLE;
      default:  state_d = ST_RST;
    endcase

    tag_in_c.vld   = accept_c;
    tag_in_c.first = accept_c && first_c;
    tag_in_c.last  = accept_c && bus.in_last;

    for (int unsigned s = 1; s < DEPTH; s++) pipe_busy_c = pipe_busy_c | tag_q[s].vld;

    // The first beat's opmode zeroes Z so the previous frame's P is discarded
    if (tag_q[OPM_STAGE].vld) opmode_d = tag_q[OPM_STAGE].first ? OPM_FIRST : OPM_ACC;

    credits_d = credits_q + CRED_W'(accept_c && first_c) - CRED_W'(pop_c);
    count_d   = count_q + CRED_W'(capture_c) - CRED_W'(pop_c);
    wr_ptr_d  = wr_ptr_q ^ capture_c;
    rd_ptr_d  = rd_ptr_q ^ pop_c;

    wr_entry_c.data = bus.DSP_P;
`ifdef DSP_SEQ_OVF_EN
    ovf_sticky_d   = ovf_sticky_q;
    wr_entry_c.ovf = ovf_sticky_q | bus.DSP_CARRYOUT;
    if (tag_q[DEPTH].vld) ovf_sticky_d = capture_c ? 1'b0 : (ovf_sticky_q | bus.DSP_CARRYOUT);
`endif
    if (capture_c) mem_d[wr_ptr_q] = wr_entry_c;

    in_ready_d  = (state_q != ST_RST) &&
                  ((state_d == ST_FRAME) || (credits_d < CRED_W'(FIFO_DEPTH)));
    res_valid_d = (count_d != '0);
    busy_d      = (state_d == ST_FRAME) || pipe_busy_c;
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned s = 1; s <= DEPTH; s++) tag_q[s] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      credits_q    <= '0;
      count_q      <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      dsp_a_q      <= '0;
      dsp_b_q      <= '0;
      dsp_opmode_q <= OPM_HOLD;
      dsp_ce_q     <= 1'b0;
      dsp_rst_q    <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      busy_q       <= 1'b0;
`ifdef DSP_SEQ_OVF_EN
      ovf_sticky_q <= 1'b0;
      res_ovf_q    <= 1'b0;
`endif
    end else begin
      tag_q[1] <= tag_in_c;
      for (int unsigned s = 2; s <= DEPTH; s++) tag_q[s] <= tag_q[s-1];
      mem_q        <= mem_d;
      credits_q    <= credits_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_ready_q   <= in_ready_d;
      if (accept_c) begin
        dsp_a_q <= bus.in_a;
        dsp_b_q <= bus.in_b;
      end
      dsp_opmode_q <= opmode_d;
      dsp_ce_q     <= (state_d != ST_RST);
      dsp_rst_q    <= (state_d == ST_RST);
      res_valid_q  <= res_valid_d;
      res_data_q   <= mem_d[rd_ptr_d].data;
      busy_q       <= busy_d;
`ifdef DSP_SEQ_OVF_EN
      ovf_sticky_q <= ovf_sticky_d;
      res_ovf_q    <= mem_d[rd_ptr_d].ovf;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.DSP_A      = dsp_a_q;
  assign bus.DSP_B      = dsp_b_q;
  assign bus.DSP_OPMODE = dsp_opmode_q;
  assign bus.DSP_CE     = dsp_ce_q;
  assign bus.DSP_RST    = dsp_rst_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.busy       = busy_q;
`ifdef DSP_SEQ_OVF_EN
  assign bus.res_ovf    = res_ovf_q;
`endif
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice in its default
// register configuration. Results are checked by a queue-based scoreboard.
module tb_dsp_mac_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_mac_sequencer_if bif ();

  dsp_mac_sequencer #(.MUL_LAT(2), .P_LAT(1)) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .bus  (bif.slave)
  );

  // DSP48A1 slice: A1/B1 -> M -> P with registered OPMODE, synchronous reset
  logic [17:0] a1, b1;
  logic [35:0] m;
  logic [7:0]  opm_r;
  logic [47:0] p, xm, zm;
  logic        co;
  assign xm = (opm_r[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
  assign zm = (opm_r[3:2] == 2'b10) ? p : 48'd0;
  always @(posedge clk) begin
    if (bif.DSP_RST === 1'b1) begin
      a1 <= '0; b1 <= '0; m <= '0; opm_r <= '0; p <= '0; co <= 1'b0;
    end else if (bif.DSP_CE === 1'b1) begin
      a1    <= bif.DSP_A;
      b1    <= bif.DSP_B;
      m     <= 36'(a1) * 36'(b1);
      opm_r <= bif.DSP_OPMODE;
      {co, p} <= 49'(xm) + 49'(zm) + 49'(opm_r[5]);
    end
  end
  assign bif.DSP_P        = p;
  assign bif.DSP_CARRYOUT = co;

  typedef struct {
    logic [47:0] data;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  int          cyc    = 0;
  logic [47:0] acc_m;
  logic        ovf_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare the FIFO head against the scoreboard on every pop
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bif.res_valid === 1'b1 && bif.res_ready === 1'b1) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %0h expected no result", bif.res_data);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 64'(bif.res_data), 64'(e.data));
`ifdef DSP_SEQ_OVF_EN
          check("res_ovf", 64'(bif.res_ovf), 64'(e.ovf));
`endif
        end
      end
    end
  end

  // Offer one beat, wait (bounded) for acceptance, update the reference sum
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    int          n = 0;
    logic [48:0] s;
    exp_t        e;
    bif.in_valid = 1'b1;
    bif.in_a     = a;
    bif.in_b     = b;
    bif.in_last  = last;
    while (1) begin
      @(negedge clk);
      if (bif.in_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        bif.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    s = 49'(acc_m) + 49'(48'(a) * 48'(b));
    ovf_m = ovf_m | s[48];
    acc_m = s[47:0];
    if (last) begin
      e.data = acc_m;
      e.ovf  = ovf_m;
      exp_q.push_back(e);
      acc_m = '0;
      ovf_m = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bif.res_valid === 1'b1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bif.in_ready),   64'd0);
    check({tag, "_dsp_a"},     64'(bif.DSP_A),      64'd0);
    check({tag, "_dsp_b"},     64'(bif.DSP_B),      64'd0);
    check({tag, "_opmode"},    64'(bif.DSP_OPMODE), 64'h08);
    check({tag, "_dsp_ce"},    64'(bif.DSP_CE),     64'd0);
    check({tag, "_dsp_rst"},   64'(bif.DSP_RST),    64'd1);
    check({tag, "_res_valid"}, 64'(bif.res_valid),  64'd0);
    check({tag, "_res_data"},  64'(bif.res_data),   64'd0);
    check({tag, "_busy"},      64'(bif.busy),       64'd0);
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check({tag, "_rst_hold"}, 64'(bif.DSP_RST), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_rst_drop"}, 64'(bif.DSP_RST),  64'd0);
    check({tag, "_ce_on"},    64'(bif.DSP_CE),   64'd1);
    check({tag, "_rdy_wait"}, 64'(bif.in_ready), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_rdy_on"},   64'(bif.in_ready), 64'd1);
  endtask

  logic [7:0] exp_op [5];
  int         p0;

  initial begin
    exp_op[0] = 8'h01; exp_op[1] = 8'h08; exp_op[2] = 8'h08;
    exp_op[3] = 8'h08; exp_op[4] = 8'h09;
    bif.in_valid  = 1'b0;
    bif.in_a      = '0;
    bif.in_b      = '0;
    bif.in_last   = 1'b0;
    bif.res_ready = 1'b1;
    acc_m = '0;
    ovf_m = 1'b0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    release_reset("por");

    // Three-beat frame: 2*3+4*5+7*1 = 33, result appears 4 edges after last beat
    p0 = pops;
    send(18'd2, 18'd3, 1'b0);
    check("t1_busy_mid_frame", 64'(bif.busy), 64'd1);
    send(18'd4, 18'd5, 1'b0);
    send(18'd7, 18'd1, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t1_res_valid_early", 64'(bif.res_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    check("t1_res_valid_at_4", 64'(bif.res_valid), 64'd1);
    wait_drain("t1_drain");
    check("t1_single_pop", 64'(pops - p0), 64'd1);
    check("t1_busy_idle", 64'(bif.busy), 64'd0);

    // Back-to-back frames: 101 then 9
    send(18'd10, 18'd10, 1'b0);
    send(18'd1,  18'd1,  1'b1);
    send(18'd3,  18'd3,  1'b1);
    wait_drain("t2_drain");

    // Credit backpressure: third single-beat frame blocked until the first pop
    bif.res_ready = 1'b0;
    send(18'd1, 18'd1, 1'b1);
    send(18'd2, 18'd2, 1'b1);
    p0 = pops;
    fork
      send(18'd3, 18'd3, 1'b1);
      begin
        repeat (4) @(negedge clk);
        check("t3_in_ready_blocked", 64'(bif.in_ready),  64'd0);
        check("t3_res_valid_held",   64'(bif.res_valid), 64'd1);
        check("t3_head_data",        64'(bif.res_data),  64'd1);
        @(posedge clk);
        #1;
        bif.res_ready = 1'b1;
      end
    join
    check("t3_pop_before_third", 64'((pops - p0) >= 1), 64'd1);
    wait_drain("t3_drain");

    // Bubbles mid-frame: opmode 01,08,08,08,09 and sum 30+56 = 86
    send(18'd5, 18'd6, 1'b0);
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        send(18'd7, 18'd8, 1'b1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clk);
          #1;
          check($sformatf("t4_opmode_%0d", i), 64'(bif.DSP_OPMODE), 64'(exp_op[i]));
        end
      end
    join
    wait_drain("t4_drain");

    // Reset mid-frame, then a fresh single-beat frame
    send(18'd1, 18'd2, 1'b0);
    send(18'd3, 18'd4, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    acc_m = '0;
    ovf_m = 1'b0;
    release_reset("mid");
    send(18'd2, 18'd2, 1'b1);
    wait_drain("t5_drain");

`ifdef DSP_SEQ_OVF_EN
    // Long frame of maximum operands wraps the 48-bit sum and sets res_ovf
    for (int i = 0; i < 4097; i++) send(18'h3FFFF, 18'h3FFFF, (i == 4096));
    send(18'd1, 18'd1, 1'b1);
    wait_drain("t6_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
